sdram_burst_master: RTL and testbench

Application-side burst initiator driving the `sdram_core` write/read burst interface. It treats a fixed SDRAM region as a circular sample buffer. Full bursts are drained from an upstream write FIFO (audio capture or file loader) into SDRAM. Full bursts are fetched back into a downstream read FIFO (playback path). Pointers, occupancy and arbitration are tracked so the playback path never reads unwritten data and the writer never overwrites unread data.

---
 rtl/sdram_burst_master.sv | 210 +++++++++++++++++++++
 tb/tb_sdram_burst_master.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_burst_master.sv
`default_nettype none
// ============================================================================
//  Module   : sdram_burst_master
//  Purpose  : Burst initiator for sdram_core. Treats a fixed SDRAM region as a
//             circular sample buffer: drains full bursts from an upstream write
//             FIFO into SDRAM and fetches full bursts back into a downstream
//             read FIFO, tracking pointers and occupancy so that neither side
//             overruns the other.
//  Options  : SDRAM_BURST_MASTER_RR_EN - round-robin arbitration between write
//             and read bursts (default build: fixed read priority).
//  Revision : 1.0 - initial release
// ============================================================================
module sdram_burst_master #(
  parameter int APP_ADDR_WIDTH  = 24,
  parameter int APP_BURST_WIDTH = 10,
  parameter int DQ_WIDTH        = 16,
  parameter int LEVEL_WIDTH     = 10,
  parameter int BURST_LEN       = 256,
  parameter int BASE_ADDR       = 0,
  parameter int REGION_SIZE     = 65536
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic                        flush,
  input  logic [LEVEL_WIDTH-1:0]      wf_level,
  output logic                        wf_rd_en,
  input  logic [DQ_WIDTH-1:0]         wf_dout,
  input  logic [LEVEL_WIDTH-1:0]      rf_free,
  output logic                        rf_wr_en,
  output logic [DQ_WIDTH-1:0]         rf_din,
  output logic                        wr_burst_req,
  output logic                        rd_burst_req,
  output logic [APP_BURST_WIDTH-1:0]  wr_burst_len,
  output logic [APP_BURST_WIDTH-1:0]  rd_burst_len,
  output logic [APP_ADDR_WIDTH-1:0]   wr_burst_addr,
  output logic [APP_ADDR_WIDTH-1:0]   rd_burst_addr,
  output logic [DQ_WIDTH-1:0]         wr_burst_data,
  input  logic                        wr_burst_data_req,
  input  logic                        wr_burst_finish,
  input  logic                        rd_burst_data_valid,
  input  logic                        rd_burst_finish,
  input  logic [DQ_WIDTH-1:0]         rd_burst_data,
  output logic [$clog2(REGION_SIZE):0] occupancy,
  output logic                        busy
);

  localparam int PTR_W = $clog2(REGION_SIZE);
  localparam int OCC_W = PTR_W + 1;

  // Burst size expressed in each of the widths it is compared/added against.
  localparam logic [PTR_W-1:0]     BURST_PTR = PTR_W'(BURST_LEN);
  localparam logic [OCC_W-1:0]     BURST_OCC = OCC_W'(BURST_LEN);
  localparam logic [OCC_W-1:0]     WR_LIMIT  = OCC_W'(REGION_SIZE - BURST_LEN);
  localparam logic [LEVEL_WIDTH:0] LVL_MIN   = (LEVEL_WIDTH + 1)'(BURST_LEN);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_REQ  = 3'd1,
    S_WR_DATA = 3'd2,
    S_RD_REQ  = 3'd3,
    S_RD_DATA = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]   occ_q, occ_d;
  logic               wr_req_q, wr_req_d;
  logic               rd_req_q, rd_req_d;

  logic               wr_ok, rd_ok;
  logic               grant_wr, grant_rd;

  // Eligibility: a write needs a full burst waiting and a full burst of free
  // region; a read needs room downstream and a full burst already committed.
  always_comb begin
    wr_ok = enable && ({1'b0, wf_level} >= LVL_MIN) && (occ_q <= WR_LIMIT);
    rd_ok = enable && ({1'b0, rf_free} >= LVL_MIN) && (occ_q >= BURST_OCC);
  end

`ifdef SDRAM_BURST_MASTER_RR_EN
  // Remembers whether the most recent grant went to the read side.
  logic last_rd_q, last_rd_d;

  // Round-robin: under contention the side not served last wins.
  always_comb begin
    grant_rd = rd_ok && (!wr_ok || !last_rd_q);
    grant_wr = wr_ok && !grant_rd;
  end
`else
  // Fixed priority: reads always win to keep playback from starving.
  always_comb begin
    grant_rd = rd_ok;
    grant_wr = wr_ok && !grant_rd;
  end
`endif

  // Next-state, pointer and occupancy logic. Occupancy only moves on finish so
  // space/data are committed after the SDRAM transfer is complete.
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    wr_req_d = wr_req_q;
    rd_req_d = rd_req_q;
`ifdef SDRAM_BURST_MASTER_RR_EN
    last_rd_d = last_rd_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (flush) begin
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          occ_d    = '0;
        end else if (grant_rd) begin
          state_d  = S_RD_REQ;
          rd_req_d = 1'b1;
`ifdef SDRAM_BURST_MASTER_RR_EN
          last_rd_d = 1'b1;
`endif
        end else if (grant_wr) begin
          state_d  = S_WR_REQ;
          wr_req_d = 1'b1;
`ifdef SDRAM_BURST_MASTER_RR_EN
          last_rd_d = 1'b0;
`endif
        end
      end
      // Request is held through any refresh the core performs first.
      S_WR_REQ: begin
        if (wr_burst_data_req) begin
          state_d  = S_WR_DATA;
          wr_req_d = 1'b0;
        end
      end
      S_WR_DATA: begin
        if (wr_burst_finish) begin
          wr_ptr_d = wr_ptr_q + BURST_PTR;
          occ_d    = occ_q + BURST_OCC;
          state_d  = S_IDLE;
        end
      end
      S_RD_REQ: begin
        if (rd_burst_data_valid) begin
          state_d  = S_RD_DATA;
          rd_req_d = 1'b0;
        end
      end
      S_RD_DATA: begin
        if (rd_burst_finish) begin
          rd_ptr_d = rd_ptr_q + BURST_PTR;
          occ_d    = occ_q - BURST_OCC;
          state_d  = S_IDLE;
        end
      end
      default: begin
        state_d  = S_IDLE;
        wr_req_d = 1'b0;
        rd_req_d = 1'b0;
      end
    endcase
  end

  // State register with asynchronous reset shared with sdram_core.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      wr_req_q <= 1'b0;
      rd_req_q <= 1'b0;
`ifdef SDRAM_BURST_MASTER_RR_EN
      last_rd_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      wr_req_q <= wr_req_d;
      rd_req_q <= rd_req_d;
`ifdef SDRAM_BURST_MASTER_RR_EN
      last_rd_q <= last_rd_d;
`endif
    end
  end

  // Region is aligned to its size, so base + pointer never carries into the
  // base bits and bursts never straddle a column page.
  assign wr_burst_addr = APP_ADDR_WIDTH'(BASE_ADDR) + APP_ADDR_WIDTH'(wr_ptr_q);
  assign rd_burst_addr = APP_ADDR_WIDTH'(BASE_ADDR) + APP_ADDR_WIDTH'(rd_ptr_q);
  assign wr_burst_len  = APP_BURST_WIDTH'(BURST_LEN);
  assign rd_burst_len  = APP_BURST_WIDTH'(BURST_LEN);
  assign wr_burst_req  = wr_req_q;
  assign rd_burst_req  = rd_req_q;

  // Zero-latency data paths between the FIFOs and the core.
  assign wf_rd_en      = wr_burst_data_req;
  assign wr_burst_data = wf_dout;
  assign rf_wr_en      = rd_burst_data_valid;
  assign rf_din        = rd_burst_data;

  assign occupancy = occ_q;
  assign busy      = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sdram_burst_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sdram_burst_master
//  Purpose  : Directed self-checking bench for sdram_burst_master with a small
//             sdram_core behavioural stand-in and a pointer/occupancy model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sdram_burst_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable, flush;
  logic [9:0]  wf_level, rf_free;
  logic        wf_rd_en, rf_wr_en;
  logic [15:0] wf_dout, rf_din, wr_burst_data, rd_burst_data;
  logic        wr_burst_req, rd_burst_req;
  logic [9:0]  wr_burst_len, rd_burst_len;
  logic [23:0] wr_burst_addr, rd_burst_addr;
  logic        wr_burst_data_req, wr_burst_finish, rd_burst_data_valid, rd_burst_finish;
  logic [16:0] occupancy;
  logic        busy;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          exp_wr_ptr, exp_rd_ptr, exp_occ;
  bit          chk_data;
  logic [15:0] mem [0:65535];
  logic [3:0]  grants, exp_grants;
  int          w, hits;

  always #5 clk = ~clk;

  sdram_burst_master dut (
    .clk(clk), .rst(rst), .enable(enable), .flush(flush),
    .wf_level(wf_level), .wf_rd_en(wf_rd_en), .wf_dout(wf_dout),
    .rf_free(rf_free), .rf_wr_en(rf_wr_en), .rf_din(rf_din),
    .wr_burst_req(wr_burst_req), .rd_burst_req(rd_burst_req),
    .wr_burst_len(wr_burst_len), .rd_burst_len(rd_burst_len),
    .wr_burst_addr(wr_burst_addr), .rd_burst_addr(rd_burst_addr),
    .wr_burst_data(wr_burst_data),
    .wr_burst_data_req(wr_burst_data_req), .wr_burst_finish(wr_burst_finish),
    .rd_burst_data_valid(rd_burst_data_valid), .rd_burst_finish(rd_burst_finish),
    .rd_burst_data(rd_burst_data), .occupancy(occupancy), .busy(busy)
  );

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] pat(input logic [23:0] x);
    return x[15:0] * 16'd3 + 16'h1234;
  endfunction

  // Plays the sdram_core side of one burst: wait for the request, optionally
  // stall (refresh), stream nwords, pulse finish, then check the committed state.
  task automatic run_burst(input bit is_wr, input int delay, input int nwords);
    logic [23:0] a, ai;
    int          waited, held, pulses, derr;
    logic        req_after;
    waited = 0;
    while (!(is_wr ? wr_burst_req : rd_burst_req) && waited < 50) begin
      step();
      waited++;
    end
    check_eq("req_seen", is_wr ? wr_burst_req : rd_burst_req, 1);
    if (waited >= 50) return;
    a = is_wr ? wr_burst_addr : rd_burst_addr;
    check_eq("burst_addr", a, is_wr ? exp_wr_ptr : exp_rd_ptr);
    held = 1;
    for (int i = 0; i < delay; i++) begin
      step();
      if (is_wr ? wr_burst_req : rd_burst_req) held++;
    end
    if (delay > 0) check_eq("req_held_refresh", held, delay + 1);
    pulses = 0; derr = 0; req_after = 1'b1;
    for (int i = 0; i < nwords; i++) begin
      ai = a + 24'(i);
      if (is_wr) begin
        wr_burst_data_req = 1'b1;
        wf_dout = pat(ai);
      end else begin
        rd_burst_data_valid = 1'b1;
        rd_burst_data = mem[ai[15:0]];
      end
      #1;
      if (is_wr) begin
        if (wf_rd_en) pulses++;
        mem[ai[15:0]] = wr_burst_data;
      end else begin
        if (rf_wr_en) pulses++;
        if (chk_data && rf_din !== pat(ai)) derr++;
      end
      step();
      if (i == 0) req_after = is_wr ? wr_burst_req : rd_burst_req;
    end
    wr_burst_data_req = 1'b0;
    rd_burst_data_valid = 1'b0;
    check_eq("req_dropped", req_after, 0);
    check_eq("data_pulses", pulses, nwords);
    if (!is_wr && chk_data) check_eq("rd_data_errors", derr, 0);
    if (is_wr) wr_burst_finish = 1'b1;
    else       rd_burst_finish = 1'b1;
    step();
    wr_burst_finish = 1'b0;
    rd_burst_finish = 1'b0;
    if (is_wr) begin
      exp_wr_ptr = (exp_wr_ptr + 256) % 65536;
      exp_occ    = exp_occ + 256;
    end else begin
      exp_rd_ptr = (exp_rd_ptr + 256) % 65536;
      exp_occ    = exp_occ - 256;
    end
    check_eq("occ_after_finish", occupancy, exp_occ);
    check_eq("busy_after_finish", busy, 0);
    check_eq("next_addr", is_wr ? wr_burst_addr : rd_burst_addr,
             is_wr ? exp_wr_ptr : exp_rd_ptr);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; flush = 1'b0; wf_level = '0; rf_free = '0;
    wf_dout = '0; rd_burst_data = '0; wr_burst_data_req = 1'b0; wr_burst_finish = 1'b0;
    rd_burst_data_valid = 1'b0; rd_burst_finish = 1'b0;
    exp_wr_ptr = 0; exp_rd_ptr = 0; exp_occ = 0; chk_data = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_wr_req", wr_burst_req, 0);
    check_eq("rst_rd_req", rd_burst_req, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_occ", occupancy, 0);
    check_eq("rst_wr_addr", wr_burst_addr, 0);
    check_eq("rst_rd_addr", rd_burst_addr, 0);
    check_eq("rst_wf_rd_en", wf_rd_en, 0);
    check_eq("rst_rf_wr_en", rf_wr_en, 0);
    check_eq("wr_len", wr_burst_len, 256);
    check_eq("rd_len", rd_burst_len, 256);
    rst = 1'b0;
    step();

    // First write burst: request one cycle after eligibility is seen.
    enable = 1'b1; wf_level = 10'd256;
    check_eq("req_before_edge", wr_burst_req, 0);
    step();
    check_eq("req_latency", wr_burst_req, 1);
    wf_level = '0;
    run_burst(1'b1, 0, 256);

    // Read the same burst back and compare data.
    chk_data = 1'b1; rf_free = 10'd300;
    step();
    rf_free = '0;
    run_burst(1'b0, 0, 256);
    chk_data = 1'b0;

    // Flush held across a write burst takes effect only back in IDLE.
    wf_level = 10'd256;
    step();
    wf_level = '0; flush = 1'b1;
    run_burst(1'b1, 0, 8);
    step();
    flush = 1'b0;
    exp_wr_ptr = 0; exp_rd_ptr = 0; exp_occ = 0;
    check_eq("flush_occ", occupancy, 0);
    check_eq("flush_wr_addr", wr_burst_addr, 0);
    check_eq("flush_rd_addr", rd_burst_addr, 0);

    // Fill the whole region; writer must then stall with the pointer wrapped.
    wf_level = 10'd256;
    for (int k = 0; k < 256; k++) run_burst(1'b1, 0, 1);
    check_eq("full_occ", occupancy, 65536);
    check_eq("full_wr_wrap", wr_burst_addr, 0);
    hits = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (wr_burst_req || busy) hits++;
    end
    check_eq("full_no_write", hits, 0);
    rf_free = 10'd300;
    step();
    rf_free = '0;
    run_burst(1'b0, 0, 1);
    run_burst(1'b1, 0, 1);
    wf_level = '0;

    // Contention between both directions.
    flush = 1'b1;
    step();
    flush = 1'b0;
    exp_wr_ptr = 0; exp_rd_ptr = 0; exp_occ = 0;
    check_eq("flush2_occ", occupancy, 0);
    wf_level = 10'd256;
    run_burst(1'b1, 0, 1);
    run_burst(1'b1, 0, 1);
    rf_free = 10'd300;
    grants = '0;
    for (int k = 0; k < 4; k++) begin
      w = 0;
      while (!wr_burst_req && !rd_burst_req && w < 20) begin
        step();
        w++;
      end
      check_eq("idle_gap", w, 1);
      grants[k] = rd_burst_req;
      run_burst(!rd_burst_req, 0, 1);
    end
    wf_level = '0; rf_free = '0;
`ifdef SDRAM_BURST_MASTER_RR_EN
    exp_grants = 4'b0101;
`else
    exp_grants = 4'b1011;
`endif
    check_eq("grant_order", grants, exp_grants);

    // Core stalls 40 cycles for refresh before taking the write burst.
    wf_level = 10'd256;
    step();
    wf_level = '0;
    run_burst(1'b1, 40, 256);
    step();
    check_eq("single_burst_idle", busy, 0);

    // Asynchronous reset in the middle of a read burst.
    rf_free = 10'd300;
    step();
    rf_free = '0;
    rd_burst_data_valid = 1'b1;
    step();
    step();
    check_eq("pre_rst_busy", busy, 1);
    rst = 1'b1;
    rd_burst_data_valid = 1'b0;
    #1;
    check_eq("mid_rst_rd_req", rd_burst_req, 0);
    check_eq("mid_rst_wr_req", wr_burst_req, 0);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_occ", occupancy, 0);
    check_eq("mid_rst_wr_addr", wr_burst_addr, 0);
    check_eq("mid_rst_rd_addr", rd_burst_addr, 0);
    check_eq("mid_rst_rf_wr_en", rf_wr_en, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
